// File: rtl/mem_cdb_arbiter_if.sv
// mem_cdb_arbiter_if
// Bundles the MEM and ALU write-back inputs, the registered CDB write port
// and the status outputs of the CDB arbiter.
//   mem_*_i   : MEM pipeline result (regwrite = push valid)
//   alu_*_i   : ALU pipeline result (regwrite = valid, fixed priority)
//   cdb_*_o   : registered CDB write, cdb_src_mem_o marks a MEM-sourced entry
//   mem_stall_o, alu_stall_o, fifo_count_o, overflow_err_o : status
// Modports: master drives the pipeline results and observes the CDB,
// slave is the arbiter itself.
// Handshake: there is no ready path back to the producers. A result is
// accepted in every cycle its regwrite is high; producers must honour
// mem_stall_o / alu_stall_o upstream, one CDB write leaves per cycle.
interface mem_cdb_arbiter_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          mem_regwrite_i;
    logic [2:0]    mem_warpID_i;
    logic [1:0]    mem_scbID_i;
    logic [4:0]    mem_reg_addr_i;
    logic [7:0]    mem_mask_i;
    logic [255:0]  mem_data_i;
    logic [31:0]   mem_instr_i;

    logic          alu_regwrite_i;
    logic [2:0]    alu_warpID_i;
    logic [1:0]    alu_scbID_i;
    logic [4:0]    alu_reg_addr_i;
    logic [7:0]    alu_mask_i;
    logic [255:0]  alu_data_i;
    logic [31:0]   alu_instr_i;

    logic          cdb_valid_o;
    logic          cdb_src_mem_o;
    logic [2:0]    cdb_warpID_o;
    logic [1:0]    cdb_scbID_o;
    logic [4:0]    cdb_reg_addr_o;
    logic [7:0]    cdb_mask_o;
    logic [255:0]  cdb_data_o;
    logic [31:0]   cdb_instr_o;

    logic          mem_stall_o;
    logic          alu_stall_o;
    logic [CW-1:0] fifo_count_o;
    logic          overflow_err_o;

    modport master (
        output mem_regwrite_i, mem_warpID_i, mem_scbID_i, mem_reg_addr_i,
               mem_mask_i, mem_data_i, mem_instr_i,
        output alu_regwrite_i, alu_warpID_i, alu_scbID_i, alu_reg_addr_i,
               alu_mask_i, alu_data_i, alu_instr_i,
        input  cdb_valid_o, cdb_src_mem_o, cdb_warpID_o, cdb_scbID_o,
               cdb_reg_addr_o, cdb_mask_o, cdb_data_o, cdb_instr_o,
        input  mem_stall_o, alu_stall_o, fifo_count_o, overflow_err_o
    );

    modport slave (
        input  mem_regwrite_i, mem_warpID_i, mem_scbID_i, mem_reg_addr_i,
               mem_mask_i, mem_data_i, mem_instr_i,
        input  alu_regwrite_i, alu_warpID_i, alu_scbID_i, alu_reg_addr_i,
               alu_mask_i, alu_data_i, alu_instr_i,
        output cdb_valid_o, cdb_src_mem_o, cdb_warpID_o, cdb_scbID_o,
               cdb_reg_addr_o, cdb_mask_o, cdb_data_o, cdb_instr_o,
        output mem_stall_o, alu_stall_o, fifo_count_o, overflow_err_o
    );
endinterface

// File: rtl/mem_cdb_arbiter.sv
// mem_cdb_arbiter
// Write-back arbiter onto the common data bus. ALU results have fixed
// priority; MEM results that cannot go straight out are queued in a FIFO
// and drain in ALU-free cycles. One registered CDB write per cycle.
// Ports:
//   clk  : clock
//   rst  : asynchronous, active-low reset
//   bus  : mem_cdb_arbiter_if.slave (MEM/ALU inputs, CDB outputs, status)
module mem_cdb_arbiter #(
    parameter int DEPTH        = 8,
    parameter int SKID         = 5,
    parameter int STARVE_LIMIT = 16
) (
    input logic              clk,
    input logic              rst,
    mem_cdb_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    // Occupancy at which fewer than SKID+1 slots remain free.
    localparam logic [31:0] STALL_AT = 32'((DEPTH > SKID) ? (DEPTH - SKID) : 0);

    typedef struct packed {
        logic [2:0]   warp;
        logic [1:0]   scb;
        logic [4:0]   reg_addr;
        logic [7:0]   mask;
        logic [255:0] data;
        logic [31:0]  instr;
    } wb_entry_t;

    wb_entry_t mem_in, alu_in, grant_e;
    wb_entry_t fifo_q [DEPTH];
    wb_entry_t cdb_q;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          alu_stall_q, alu_stall_d;
    logic          ovf_q;
    logic          cdb_valid_q, cdb_src_q;

    logic fifo_empty, fifo_full;
    logic pop, bypass, push_req, push_ok, drop;
    logic grant_v, grant_src;

    assign mem_in = {bus.mem_warpID_i, bus.mem_scbID_i, bus.mem_reg_addr_i,
                     bus.mem_mask_i, bus.mem_data_i, bus.mem_instr_i};
    assign alu_in = {bus.alu_warpID_i, bus.alu_scbID_i, bus.alu_reg_addr_i,
                     bus.alu_mask_i, bus.alu_data_i, bus.alu_instr_i};

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CW'(DEPTH));
        pop        = !bus.alu_regwrite_i && !fifo_empty;
        // An empty FIFO lets a lone MEM result skip the queue entirely.
        bypass     = !bus.alu_regwrite_i && fifo_empty && bus.mem_regwrite_i;
        push_req   = bus.mem_regwrite_i && !bypass;
        // A pop in the same cycle frees the slot a full FIFO needs.
        push_ok    = push_req && (!fifo_full || pop);
        drop       = push_req && fifo_full && !pop;

        grant_v   = 1'b1;
        grant_src = 1'b0;
        grant_e   = alu_in;
        if (bus.alu_regwrite_i) begin
            grant_src = 1'b0;
            grant_e   = alu_in;
        end else if (pop) begin
            grant_src = 1'b1;
            grant_e   = fifo_q[rd_ptr_q];
        end else if (bypass) begin
            grant_src = 1'b1;
            grant_e   = mem_in;
        end else begin
            grant_v = 1'b0;
        end

        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push_ok) begin
            count_d = count_q - 1'b1;
        end

        // Counts cycles a waiting head is passed over; saturates at the limit.
        starve_d = starve_q;
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (starve_q != SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + 1'b1;
        end
        alu_stall_d = (starve_d == SW'(STARVE_LIMIT));
    end

    // Storage needs no reset: only entries written since reset are ever read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_q[wr_ptr_q] <= mem_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            alu_stall_q <= 1'b0;
            ovf_q       <= 1'b0;
            cdb_valid_q <= 1'b0;
            cdb_src_q   <= 1'b0;
            cdb_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            alu_stall_q <= alu_stall_d;
            ovf_q       <= ovf_q | drop;
            cdb_valid_q <= grant_v;
            if (grant_v) begin
                cdb_src_q <= grant_src;
                cdb_q     <= grant_e;
            end
        end
    end

    assign bus.cdb_valid_o    = cdb_valid_q;
    assign bus.cdb_src_mem_o  = cdb_src_q;
    assign bus.cdb_warpID_o   = cdb_q.warp;
    assign bus.cdb_scbID_o    = cdb_q.scb;
    assign bus.cdb_reg_addr_o = cdb_q.reg_addr;
    assign bus.cdb_mask_o     = cdb_q.mask;
    assign bus.cdb_data_o     = cdb_q.data;
    assign bus.cdb_instr_o    = cdb_q.instr;
    assign bus.mem_stall_o    = (32'(count_q) >= STALL_AT);
    assign bus.alu_stall_o    = alu_stall_q;
    assign bus.fifo_count_o   = count_q;
    assign bus.overflow_err_o = ovf_q;
endmodule

// File: tb/tb_mem_cdb_arbiter.sv
module tb_mem_cdb_arbiter;
    localparam int DEPTH = 8;
    localparam int SKID  = 5;
    localparam int LIMIT = 16;
    localparam int W     = 307;

    typedef struct packed {
        logic [2:0]   warp;
        logic [1:0]   scb;
        logic [4:0]   ra;
        logic [7:0]   mask;
        logic [255:0] data;
        logic [31:0]  instr;
    } ent_t;

    logic clk;
    logic rst;

    mem_cdb_arbiter_if #(.DEPTH(DEPTH)) bus ();

    mem_cdb_arbiter #(.DEPTH(DEPTH), .SKID(SKID), .STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard and reference state
    logic [W-1:0] exp_q [$];
    ent_t         m_q [$];
    int           m_starve;
    logic         m_stall;
    logic         m_ovf;
    logic         exp_v;
    logic [W-1:0] last_cdb;
    int           vectors;
    int           miscompares;

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t rand_ent();
        ent_t e;
        e.warp  = 3'($urandom_range(0, 7));
        e.scb   = 2'($urandom_range(0, 3));
        e.ra    = 5'($urandom_range(0, 31));
        e.mask  = 8'($urandom_range(0, 255));
        for (int i = 0; i < 8; i++) e.data[i*32 +: 32] = $urandom;
        e.instr = $urandom;
        return e;
    endfunction

    function automatic logic [W-1:0] cur_cdb();
        return {bus.cdb_src_mem_o, bus.cdb_warpID_o, bus.cdb_scbID_o, bus.cdb_reg_addr_o,
                bus.cdb_mask_o, bus.cdb_data_o, bus.cdb_instr_o};
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, bus.cdb_valid_o, 0);
        chk({tag, "_cdb"}, cur_cdb(), 0);
        chk({tag, "_count"}, bus.fifo_count_o, 0);
        chk({tag, "_mem_stall"}, bus.mem_stall_o, 0);
        chk({tag, "_alu_stall"}, bus.alu_stall_o, 0);
        chk({tag, "_ovf"}, bus.overflow_err_o, 0);
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_q.delete();
        m_starve = 0;
        m_stall  = 1'b0;
        m_ovf    = 1'b0;
        last_cdb = '0;
    endtask

    // driver: apply one cycle of inputs, predict, then check after the edge
    task automatic step(input logic av, input ent_t ae, input logic mv, input ent_t me);
        logic [W-1:0] e;
        logic         pop;
        logic         byp;
        int           sz;
        bus.alu_regwrite_i = av;
        {bus.alu_warpID_i, bus.alu_scbID_i, bus.alu_reg_addr_i, bus.alu_mask_i,
         bus.alu_data_i, bus.alu_instr_i} = ae;
        bus.mem_regwrite_i = mv;
        {bus.mem_warpID_i, bus.mem_scbID_i, bus.mem_reg_addr_i, bus.mem_mask_i,
         bus.mem_data_i, bus.mem_instr_i} = me;

        sz    = m_q.size();
        pop   = 1'b0;
        byp   = 1'b0;
        exp_v = 1'b1;
        e     = '0;
        if (av) e = {1'b0, ae};
        else if (sz != 0) begin e = {1'b1, m_q[0]}; pop = 1'b1; end
        else if (mv) begin e = {1'b1, me}; byp = 1'b1; end
        else exp_v = 1'b0;
        if (exp_v) begin
            exp_q.push_back(e);
            last_cdb = e;
        end
        if (pop) void'(m_q.pop_front());
        if (mv && !byp) begin
            if (sz < DEPTH || pop) m_q.push_back(me);
            else m_ovf = 1'b1;
        end
        if (pop || sz == 0) m_starve = 0;
        else if (m_starve < LIMIT) m_starve++;
        m_stall = (m_starve == LIMIT);

        @(posedge clk);
        #1;
        chk("cdb_valid", bus.cdb_valid_o, exp_v);
        if (bus.cdb_valid_o) begin
            vectors++;
            assert (exp_q.size() > 0) else begin
                miscompares++;
                $error("FAIL cdb_unexpected: observed %0h expected no write", cur_cdb());
            end
            if (exp_q.size() > 0) chk("cdb_word", cur_cdb(), exp_q.pop_front());
        end else begin
            chk("cdb_hold", cur_cdb(), last_cdb);
        end
        chk("count", bus.fifo_count_o, m_q.size());
        chk("mem_stall", bus.mem_stall_o, (DEPTH - m_q.size()) <= SKID);
        chk("alu_stall", bus.alu_stall_o, m_stall);
        chk("overflow", bus.overflow_err_o, m_ovf);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        ent_t a;
        ent_t m;
        vectors     = 0;
        miscompares = 0;
        model_clear();
        rst = 1'b0;
        bus.alu_regwrite_i = 1'b0;
        bus.mem_regwrite_i = 1'b0;
        {bus.alu_warpID_i, bus.alu_scbID_i, bus.alu_reg_addr_i, bus.alu_mask_i,
         bus.alu_data_i, bus.alu_instr_i} = '0;
        {bus.mem_warpID_i, bus.mem_scbID_i, bus.mem_reg_addr_i, bus.mem_mask_i,
         bus.mem_data_i, bus.mem_instr_i} = '0;

        // reset state
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // idle MEM bypass: reg 5, mask FF, lane i = i
        m = rand_ent();
        m.ra   = 5'd5;
        m.mask = 8'hFF;
        for (int i = 0; i < 8; i++) m.data[i*32 +: 32] = i;
        step(1'b0, '0, 1'b1, m);
        chk("byp_src", bus.cdb_src_mem_o, 1);
        chk("byp_reg", bus.cdb_reg_addr_o, 5);
        chk("byp_lane7", bus.cdb_data_o[255:224], 7);
        chk("byp_count", bus.fifo_count_o, 0);

        // collision: ALU warp 2 vs MEM warp 3
        a = rand_ent(); a.warp = 3'd2;
        m = rand_ent(); m.warp = 3'd3;
        step(1'b1, a, 1'b1, m);
        chk("col_alu_warp", bus.cdb_warpID_o, 2);
        chk("col_alu_src", bus.cdb_src_mem_o, 0);
        chk("col_count1", bus.fifo_count_o, 1);
        idle();
        chk("col_mem_warp", bus.cdb_warpID_o, 3);
        chk("col_mem_src", bus.cdb_src_mem_o, 1);
        chk("col_count0", bus.fifo_count_o, 0);

        // fill and throttle
        for (int i = 0; i < 3; i++) step(1'b1, rand_ent(), 1'b1, rand_ent());
        chk("fill_count", bus.fifo_count_o, 3);
        chk("fill_stall", bus.mem_stall_o, 1);
        idle();
        chk("drain_count2", bus.fifo_count_o, 2);
        chk("drain_stall_low", bus.mem_stall_o, 0);
        idle();
        idle();
        chk("drain_count0", bus.fifo_count_o, 0);

        // overflow: nine pushes against a busy ALU
        for (int i = 0; i < 9; i++) step(1'b1, rand_ent(), 1'b1, rand_ent());
        chk("ovf_count", bus.fifo_count_o, 8);
        chk("ovf_flag", bus.overflow_err_o, 1);
        for (int i = 0; i < 8; i++) idle();
        idle();
        chk("ovf_sticky", bus.overflow_err_o, 1);
        chk("ovf_empty", bus.fifo_count_o, 0);

        // starvation
        step(1'b1, rand_ent(), 1'b1, rand_ent());
        for (int i = 0; i < LIMIT - 1; i++) step(1'b1, rand_ent(), 1'b0, '0);
        chk("starve_pre", bus.alu_stall_o, 0);
        step(1'b1, rand_ent(), 1'b0, '0);
        chk("starve_set", bus.alu_stall_o, 1);
        idle();
        chk("starve_clear", bus.alu_stall_o, 0);
        chk("starve_pop_src", bus.cdb_src_mem_o, 1);

        // random mix
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)), rand_ent(), 1'($urandom_range(0, 1)), rand_ent());
        end
        while (m_q.size() != 0) idle();

        // async reset mid-drain with four entries queued
        for (int i = 0; i < 5; i++) step(1'b1, rand_ent(), 1'b1, rand_ent());
        idle();
        chk("pre_rst_count", bus.fifo_count_o, 4);
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        model_clear();
        bus.alu_regwrite_i = 1'b0;
        bus.mem_regwrite_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_idle", bus.cdb_valid_o, 0);
        m = rand_ent();
        step(1'b0, '0, 1'b1, m);
        chk("post_rst_src", bus.cdb_src_mem_o, 1);
        chk("post_rst_reg", bus.cdb_reg_addr_o, m.ra);
        chk("post_rst_count", bus.fifo_count_o, 0);
        idle();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_cdb_arbiter.md
# mem_cdb_arbiter

Write-back arbiter between the MEM pipeline, the ALU pipeline and the common data bus (CDB). The ALU result has fixed priority. MEM load results are queued in a FIFO and drain in cycles the ALU leaves free. The block drives one registered CDB write per cycle, throttles MEM issue before the FIFO can overflow, and blocks ALU issue when MEM results have waited too long.

## Interface
Parameters:
- DEPTH, 8 — MEM result FIFO entries (power of 2, ≥4).
- SKID, 5 — MEM results that can be in flight after issue stops.
- STARVE_LIMIT, 16 — consecutive cycles a non-empty FIFO may go without a grant.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- mem_regwrite_i  in  1  MEM result valid (push)
- mem_warpID_i  in  3  warp ID
- mem_scbID_i  in  2  scoreboard ID
- mem_reg_addr_i  in  5  destination register
- mem_mask_i  in  8  thread write mask
- mem_data_i  in  256  8×32-bit lane data
- mem_instr_i  in  32  instruction word
- alu_regwrite_i, alu_warpID_i, alu_scbID_i, alu_reg_addr_i, alu_mask_i, alu_data_i, alu_instr_i  in  1/3/2/5/8/256/32  ALU result, same field meanings
- cdb_valid_o  out  1  CDB write valid
- cdb_src_mem_o  out  1  1 = entry came from MEM
- cdb_warpID_o, cdb_scbID_o, cdb_reg_addr_o, cdb_mask_o, cdb_data_o, cdb_instr_o  out  3/2/5/8/256/32  CDB fields
- mem_stall_o  out  1  block MEM issue at the OC
- alu_stall_o  out  1  block ALU issue (starvation relief)
- fifo_count_o  out  $clog2(DEPTH)+1  occupancy
- overflow_err_o  out  1  sticky; a MEM push was dropped

## Operation
- Push: when mem_regwrite_i=1, enqueue all MEM fields. A push with mem_regwrite_i=0 is ignored.
- Grant, evaluated each cycle:
  - If alu_regwrite_i=1, the ALU wins.
  - Else, if the FIFO is non-empty, the FIFO head wins and is popped.
  - Else, if mem_regwrite_i=1, the MEM input bypasses the FIFO: no push, no pop, count unchanged.
  - Else, no grant.
- Output register captures the winner at posedge. cdb_valid_o=1 with cdb_src_mem_o set for that cycle; otherwise cdb_valid_o=0 and the other fields hold their last values.
- A MEM input that loses to the ALU is pushed.
- Push and pop in the same cycle leave count unchanged. Pointers wrap mod DEPTH.
- Full, with a push and no pop: the entry is dropped, overflow_err_o is set, and count stays DEPTH.
- Full, with a push and a pop: the push is accepted.
- mem_stall_o = (DEPTH − count) ≤ SKID. It is combinational from the registered count.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and not popped.
  - Clears on a pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- alu_stall_o is registered. It is 1 while the counter = STARVE_LIMIT and drops the cycle after the next pop.
- ALU priority is never overridden at the arbiter. alu_stall_o only drains the ALU pipeline upstream.

## Timing
- Reset (async, rst=0):
  - cdb_valid_o=0, cdb_src_mem_o=0, all CDB fields 0.
  - Pointers 0, count 0.
  - Starvation counter 0, alu_stall_o=0, overflow_err_o=0.
  - mem_stall_o follows count, so it is 0 unless SKID ≥ DEPTH.
- Reset mid-operation discards FIFO contents. No write-back of flushed entries.
- Latency:
  - Input to CDB is 1 cycle when granted directly (ALU, or MEM bypass).
  - A queued MEM entry appears on the CDB 1 cycle after the cycle it is popped.
- Order: MEM results leave in push order. There is no ordering between ALU and MEM.
- Throughput: at most 1 CDB write per cycle.

## Test plan
- Idle MEM bypass: FIFO empty, MEM push of reg 5, mask 0xFF, data lane i = i, no ALU → next cycle cdb_valid_o=1, cdb_src_mem_o=1, reg_addr 5; count stays 0.
- Collision: ALU (warp 2) and MEM (warp 3) valid in the same cycle → cycle+1 shows the ALU write and count=1; cycle+2 shows the MEM warp-3 write and count=0.
- Fill and throttle (DEPTH=8, SKID=5): ALU valid every cycle, MEM push 3 times → count=3, mem_stall_o=1. Then ALU idle → three MEM writes in order, mem_stall_o drops when count=2.
- Overflow: ALU held valid, 9 MEM pushes → count=8, overflow_err_o=1 after the 9th. overflow_err_o stays 1 until reset. The first 8 entries drain intact.
- Starvation (STARVE_LIMIT=16): one MEM entry queued, ALU valid 16 cycles → alu_stall_o=1. ALU then idle → pop, and alu_stall_o=0 the following cycle.
- Async reset with count=4 mid-drain → all outputs 0 immediately. After release, the first MEM push bypasses with count 0.
